demodulate_param: RTL and testbench
===================================

DEMODULATE_PARAM -- requirements
Module: demodulate_param

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: sample, result and FIFO data width.
REQ-002 SHALL have parameter QBITS, default 10: fixed-point fraction bits.
REQ-003 SHALL have parameter GAIN, default 758: demod gain, Q(QBITS) signed.
REQ-004 SHALL have parameter QUAD1, default 804: pi/4 in Q(QBITS); QUAD3 = 3*QUAD1 derived internally.
REQ-005 SHALL have ports, in order:
  - clock  in  1: rising-edge clock.
  - reset  in  1: asynchronous, active-low.
  - inA_rd_en  out  1: pop I (real) FIFO.
  - inA_empty  in  1: I FIFO empty.
  - inA_dout  in  DATA_WIDTH: I sample, signed, valid while !inA_empty (show-ahead).
  - inB_rd_en  out  1: pop Q (imag) FIFO.
  - inB_empty  in  1: Q FIFO empty.
  - inB_dout  in  DATA_WIDTH: Q sample, signed, show-ahead.
  - out_wr_en  out  1: push result.
  - out_full  in  1: output FIFO full.
  - out_din  out  DATA_WIDTH: demodulated sample, signed.

Function
REQ-006 SHALL define DEQ(x) = x / 2^QBITS, signed, truncated toward zero; QUANT(x) = x << QBITS, wrapping in DATA_WIDTH.
REQ-007 SHALL use FSM states IDLE, MULT, ARCT, DIV, ANGLE, WRITE.
REQ-008 IDLE: when !inA_empty && !inB_empty, SHALL assert inA_rd_en and inB_rd_en together for exactly one cycle, latch both douts, go to MULT; otherwise both rd_en low.
REQ-009 SHALL never pop one input FIFO without the other.
REQ-010 MULT: r = DEQ(prevI*I) - DEQ(-prevQ*Q); i = DEQ(prevI*Q) + DEQ(-prevQ*I).
  - Products 2*DATA_WIDTH wide.
  - r, i truncated to DATA_WIDTH.
  - prevI/prevQ then updated to the current I/Q.
REQ-011 ARCT: with abs_y = |i|+1:
  - if r >= 0: num = QUANT(r-abs_y), den = r+abs_y.
  - else: num = QUANT(r+abs_y), den = abs_y-r.
REQ-012 DIV: SHALL compute q = num/den, signed, truncated toward zero, by a sequential divider taking exactly DATA_WIDTH cycles; den >= 1 by construction.
REQ-013 ANGLE: angle = (r>=0 ? QUAD1 : QUAD3) - DEQ(QUAD1*q), negated if i < 0; SHALL register out_din = DEQ(GAIN*angle).
REQ-014 WRITE: SHALL assert out_wr_en for one cycle when !out_full, then return to IDLE; while out_full, SHALL hold state and out_din, with out_wr_en low.
REQ-015 Latency: for a pop at cycle T with out_full low, out_wr_en SHALL assert at cycle T+DATA_WIDTH+4.
REQ-016 Throughput: one sample per DATA_WIDTH+5 cycles; no new pop before the WRITE handshake completes.
REQ-017 Output order SHALL equal input order, with no drops or duplicates.

Reset
REQ-018 On reset low, SHALL asynchronously set state IDLE and clear prevI, prevQ, out_din, all divider registers, inA_rd_en, inB_rd_en and out_wr_en to 0.
REQ-019 Reset mid-operation SHALL discard the in-flight sample; the first sample after reset SHALL use prevI = prevQ = 0.

Configuration
REQ-020 With macro DEMODULATE_PARAM_STATS_EN defined:
  - SHALL add output port sample_count (32 bits, reset 0).
  - sample_count increments on each out_wr_en and wraps 2^32-1 -> 0.
REQ-021 Without DEMODULATE_PARAM_STATS_EN, the port and counter SHALL be absent; all other behaviour identical.

Verification (defaults)
REQ-022 After reset, feed (I,Q) = (1024,0) -> out_din = 1190, with out_wr_en at pop+36.
REQ-023 Feed (1024,0) then (1024,0) -> second output = 1; then (-1024,0) -> 2379.
REQ-024 Feed (1024,0) then (0,-1024) -> second output = -1190, checking truncation toward zero.
REQ-025 Hold out_full high for 20 cycles during WRITE -> out_wr_en low, no pops, out_din stable; release -> single push.
REQ-026 Assert reset during DIV, then feed (1024,0) -> no stale output, result 1190; sample_count (STATS_EN) = 1.
REQ-027 Stall inB only (inB_empty=1, inA non-empty) for 10 cycles -> both rd_en low; 64-sample random stream matches the C golden model exactly.

Source files
------------

// File: rtl/demodulate_param.sv
// FM discriminator fed by paired I/Q show-ahead FIFOs: conjugate product, arctan ratio via a DATA_WIDTH-cycle divider, gain.
// Define DEMODULATE_PARAM_STATS_EN to add the sample_count output.
//
// state | meaning
// IDLE  | wait for both FIFOs non-empty, pop both and latch I/Q
// MULT  | conjugate product with the previous sample, update previous
// ARCT  | form arctan ratio operands and load the divider
// DIV   | one restoring-division step per cycle
// ANGLE | map quotient to an angle, apply gain, register result
// WRITE | push result once the output FIFO has room
module demodulate_param #(
    parameter int DATA_WIDTH = 32,
    parameter int QBITS      = 10,
    parameter int GAIN       = 758,
    parameter int QUAD1      = 804
) (
    input  logic                         clock,
    input  logic                         reset,
    output logic                         inA_rd_en,
    input  logic                         inA_empty,
    input  logic signed [DATA_WIDTH-1:0] inA_dout,
    output logic                         inB_rd_en,
    input  logic                         inB_empty,
    input  logic signed [DATA_WIDTH-1:0] inB_dout,
    output logic                         out_wr_en,
    input  logic                         out_full,
    output logic signed [DATA_WIDTH-1:0] out_din
`ifdef DEMODULATE_PARAM_STATS_EN
    ,
    output logic [31:0]                  sample_count
`endif
);
    localparam int W  = DATA_WIDTH;
    localparam int W2 = 2 * DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic signed [W2-1:0] GAIN_X  = W2'(GAIN);
    localparam logic signed [W2-1:0] QUAD1_X = W2'(QUAD1);
    localparam logic signed [W-1:0]  QUAD1_W = W'(QUAD1);
    localparam logic signed [W-1:0]  QUAD3_W = W'(3 * QUAD1);

    typedef enum logic [2:0] {IDLE, MULT, ARCT, DIV, ANGLE, WRITE} state_t;

    state_t                 state_q;
    logic                   run_q;
    logic signed [W-1:0]    cur_i_q, cur_q_q, prev_i_q, prev_q_q;
    logic signed [W-1:0]    r_q, i_q, out_din_q;
    logic [W-1:0]           rem_q, quo_q, dvs_q;
    logic                   neg_q;
    logic [CW-1:0]          cnt_q;

    logic signed [W2-1:0]   pi_x, pq_x, ci_x, cq_x;
    logic signed [W-1:0]    r_d, i_d, abs_y, num_d, den_d;
    logic signed [W-1:0]    q_s, ang_base, ang_raw, ang_d, out_din_d;
    logic [W-1:0]           num_mag, den_mag, rem_d;
    logic [W:0]             rem_shift;
    logic                   div_take;

    // Signed divide by 2^QBITS rounding toward zero (bias negatives before the shift).
    function automatic logic signed [W2-1:0] deq(input logic signed [W2-1:0] x);
        logic signed [W2-1:0] bias;
        bias = x[W2-1] ? W2'({QBITS{1'b1}}) : '0;
        return (x + bias) >>> QBITS;
    endfunction

    always_comb begin
        pi_x = W2'(prev_i_q);
        pq_x = W2'(prev_q_q);
        ci_x = W2'(cur_i_q);
        cq_x = W2'(cur_q_q);
        r_d  = W'(deq(pi_x * ci_x) - deq(-pq_x * cq_x));
        i_d  = W'(deq(pi_x * cq_x) + deq(-pq_x * ci_x));

        abs_y = (i_q[W-1] ? -i_q : i_q) + W'(1);
        if (!r_q[W-1]) begin
            num_d = (r_q - abs_y) <<< QBITS;
            den_d = r_q + abs_y;
        end else begin
            num_d = (r_q + abs_y) <<< QBITS;
            den_d = abs_y - r_q;
        end
        num_mag = num_d[W-1] ? -num_d : num_d;
        den_mag = den_d[W-1] ? -den_d : den_d;

        rem_shift = {rem_q, quo_q[W-1]};
        div_take  = (rem_shift >= {1'b0, dvs_q});
        rem_d     = div_take ? W'(rem_shift - {1'b0, dvs_q}) : rem_shift[W-1:0];

        q_s       = neg_q ? -quo_q : quo_q;
        ang_base  = r_q[W-1] ? QUAD3_W : QUAD1_W;
        ang_raw   = ang_base - W'(deq(QUAD1_X * W2'(q_s)));
        ang_d     = i_q[W-1] ? -ang_raw : ang_raw;
        out_din_d = W'(deq(GAIN_X * W2'(ang_d)));
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            run_q     <= 1'b0;
            cur_i_q   <= '0;
            cur_q_q   <= '0;
            prev_i_q  <= '0;
            prev_q_q  <= '0;
            r_q       <= '0;
            i_q       <= '0;
            out_din_q <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            neg_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            run_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (inA_rd_en) begin
                        cur_i_q <= inA_dout;
                        cur_q_q <= inB_dout;
                        state_q <= MULT;
                    end
                end
                MULT: begin
                    r_q      <= r_d;
                    i_q      <= i_d;
                    prev_i_q <= cur_i_q;
                    prev_q_q <= cur_q_q;
                    state_q  <= ARCT;
                end
                ARCT: begin
                    rem_q   <= '0;
                    quo_q   <= num_mag;
                    dvs_q   <= den_mag;
                    neg_q   <= num_d[W-1] ^ den_d[W-1];
                    cnt_q   <= CW'(W - 1);
                    state_q <= DIV;
                end
                DIV: begin
                    rem_q <= rem_d;
                    quo_q <= {quo_q[W-2:0], div_take};
                    if (cnt_q == '0) state_q <= ANGLE;
                    else             cnt_q   <= cnt_q - CW'(1);
                end
                ANGLE: begin
                    out_din_q <= out_din_d;
                    state_q   <= WRITE;
                end
                WRITE: begin
                    if (!out_full) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Both FIFOs are popped by the same term so they can never get out of step.
    assign inA_rd_en = run_q && (state_q == IDLE) && !inA_empty && !inB_empty;
    assign inB_rd_en = inA_rd_en;
    assign out_wr_en = (state_q == WRITE) && !out_full;
    assign out_din   = out_din_q;

`ifdef DEMODULATE_PARAM_STATS_EN
    logic [31:0] sample_count_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)         sample_count_q <= '0;
        else if (out_wr_en) sample_count_q <= sample_count_q + 32'd1;
    end

    assign sample_count = sample_count_q;
`endif
endmodule

// File: tb/tb_demodulate_param.sv
// Bench for demodulate_param: queue-modelled I/Q/output FIFOs, directed cases and a random stream
// compared against an arithmetic reference of the demodulator.
module tb_demodulate_param;
    localparam int     DW      = 32;
    localparam int     QB      = 10;
    localparam longint GAIN_M  = 758;
    localparam longint QUAD1_M = 804;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic inA_rd_en, inA_empty, inB_rd_en, inB_empty, out_wr_en;
    logic out_full = 1'b0;
    logic signed [DW-1:0] inA_dout, inB_dout, out_din;
`ifdef DEMODULATE_PARAM_STATS_EN
    logic [31:0] sample_count;
`endif

    int checks = 0;
    int failures = 0;
    int qa[$], qb[$], got[$], exp_q[$], pop_cyc[$], wr_cyc[$];
    int cyc = 0;
    int pair_err = 0;
    int wd = 0;
    logic pa = 1'b0, pb = 1'b0, pw = 1'b0;
    logic stall_b = 1'b0;
    longint m_pi = 0, m_pq = 0;

    demodulate_param dut (
        .clock     (clock),
        .reset     (reset),
        .inA_rd_en (inA_rd_en),
        .inA_empty (inA_empty),
        .inA_dout  (inA_dout),
        .inB_rd_en (inB_rd_en),
        .inB_empty (inB_empty),
        .inB_dout  (inB_dout),
        .out_wr_en (out_wr_en),
        .out_full  (out_full),
        .out_din   (out_din)
`ifdef DEMODULATE_PARAM_STATS_EN
        ,
        .sample_count (sample_count)
`endif
    );

    always #5 clock = ~clock;

    task automatic refresh();
        inA_empty = (qa.size() == 0);
        inA_dout  = (qa.size() != 0) ? qa[0] : 0;
        inB_empty = stall_b || (qb.size() == 0);
        inB_dout  = (qb.size() != 0) ? qb[0] : 0;
    endtask

    always @(negedge clock) begin
        pa = inA_rd_en;
        pb = inB_rd_en;
        pw = out_wr_en;
        wd = out_din;
        if (pa !== pb) pair_err++;
        if (pa) pop_cyc.push_back(cyc);
        if (pw) wr_cyc.push_back(cyc);
    end

    always @(posedge clock) begin
        cyc++;
        #1;
        if (pa && qa.size() != 0) void'(qa.pop_front());
        if (pb && qb.size() != 0) void'(qb.pop_front());
        if (pw) got.push_back(wd);
        pa = 1'b0;
        pb = 1'b0;
        pw = 1'b0;
        refresh();
    end

    function automatic longint w32(longint x);
        return longint'(int'(x));
    endfunction

    function automatic longint deqm(longint x);
        return x / (longint'(1) << QB);
    endfunction

    // Reference demodulator: plain integer arithmetic on the sample and the remembered previous one.
    function automatic int model(int smp_i, int smp_q);
        longint r, i, ay, num, den, q, ang;
        r = w32(deqm(m_pi * smp_i) - deqm(-m_pq * smp_q));
        i = w32(deqm(m_pi * smp_q) + deqm(-m_pq * smp_i));
        m_pi = smp_i;
        m_pq = smp_q;
        ay = w32(((i < 0) ? -i : i) + 1);
        if (r >= 0) begin
            num = w32((r - ay) * (longint'(1) << QB));
            den = w32(r + ay);
        end else begin
            num = w32((r + ay) * (longint'(1) << QB));
            den = w32(ay - r);
        end
        q   = w32(num / den);
        ang = w32(((r >= 0) ? QUAD1_M : 3 * QUAD1_M) - deqm(QUAD1_M * q));
        if (i < 0) ang = w32(-ang);
        return int'(deqm(GAIN_M * ang));
    endfunction

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic push(int smp_i, int smp_q);
        qa.push_back(smp_i);
        qb.push_back(smp_q);
        exp_q.push_back(model(smp_i, smp_q));
        refresh();
    endtask

    task automatic clear_logs();
        got.delete();
        exp_q.delete();
        pop_cyc.delete();
        wr_cyc.delete();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        qa.delete();
        qb.delete();
        clear_logs();
        m_pi = 0;
        m_pq = 0;
        stall_b = 1'b0;
        out_full = 1'b0;
        refresh();
        repeat (3) tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic wait_out(int n, int budget, string tag);
        int k = 0;
        while (got.size() < n && k < budget) begin
            tick();
            k++;
        end
        checks++;
        if (got.size() < n) begin
            failures++;
            $display("FAIL %s_timeout outputs got=%0d exp=%0d", tag, got.size(), n);
        end
    endtask

    task automatic wait_pop(int n, int budget, string tag);
        int k = 0;
        while (pop_cyc.size() < n && k < budget) begin
            tick();
            k++;
        end
        checks++;
        if (pop_cyc.size() < n) begin
            failures++;
            $display("FAIL %s_pop_timeout pops got=%0d exp=%0d", tag, pop_cyc.size(), n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        push(1024, 0);
        repeat (3) tick();
        checks++;
        if (out_din !== 32'sd0) begin failures++; $display("FAIL reset_out_din got=%0d exp=0", out_din); end
        checks++;
        if (out_wr_en !== 1'b0) begin failures++; $display("FAIL reset_wr_en got=%b exp=0", out_wr_en); end
        checks++;
        if (inA_rd_en !== 1'b0 || inB_rd_en !== 1'b0) begin
            failures++; $display("FAIL reset_rd_en got=%b%b exp=00", inA_rd_en, inB_rd_en);
        end
        checks++;
        if (qa.size() != 1) begin failures++; $display("FAIL reset_no_pop qa_size=%0d exp=1", qa.size()); end
        do_reset();
    endtask

    task automatic test_first_sample();
        clear_logs();
        push(1024, 0);
        wait_out(1, 100, "first");
        checks++;
        if (got[0] !== 1190) begin failures++; $display("FAIL first_out got=%0d exp=1190", got[0]); end
        checks++;
        if (wr_cyc[0] - pop_cyc[0] !== 36) begin
            failures++; $display("FAIL first_latency got=%0d exp=36", wr_cyc[0] - pop_cyc[0]);
        end
    endtask

    task automatic test_sequence();
        clear_logs();
        push(1024, 0);
        push(-1024, 0);
        wait_out(2, 200, "seq");
        checks++;
        if (got[0] !== 1) begin failures++; $display("FAIL seq_same_phase got=%0d exp=1", got[0]); end
        checks++;
        if (got[1] !== 2379) begin failures++; $display("FAIL seq_half_turn got=%0d exp=2379", got[1]); end
        checks++;
        if (pop_cyc[1] - pop_cyc[0] !== 37) begin
            failures++; $display("FAIL seq_throughput got=%0d exp=37", pop_cyc[1] - pop_cyc[0]);
        end
    endtask

    task automatic test_negative_q();
        do_reset();
        push(1024, 0);
        push(0, -1024);
        wait_out(2, 200, "negq");
        checks++;
        if (got[0] !== 1190) begin failures++; $display("FAIL negq_first got=%0d exp=1190", got[0]); end
        checks++;
        if (got[1] !== -1190) begin failures++; $display("FAIL negq_second got=%0d exp=-1190", got[1]); end
    endtask

    task automatic test_backpressure();
        int bad_wr = 0;
        int bad_din = 0;
        clear_logs();
        out_full = 1'b1;
        push(300, -200);
        push(500, 700);
        wait_pop(1, 50, "bp");
        repeat (36) tick();
        for (int c = 0; c < 20; c++) begin
            if (out_wr_en !== 1'b0) bad_wr++;
            if (out_din !== exp_q[0]) bad_din++;
            tick();
        end
        checks++;
        if (bad_wr != 0) begin failures++; $display("FAIL bp_wr_while_full cycles=%0d exp=0", bad_wr); end
        checks++;
        if (bad_din != 0) begin failures++; $display("FAIL bp_din_stable bad_cycles=%0d exp=0", bad_din); end
        checks++;
        if (pop_cyc.size() != 1 || got.size() != 0) begin
            failures++; $display("FAIL bp_hold pops=%0d pushes=%0d exp=1,0", pop_cyc.size(), got.size());
        end
        out_full = 1'b0;
        wait_out(2, 200, "bp");
        checks++;
        if (got[0] !== exp_q[0]) begin failures++; $display("FAIL bp_out0 got=%0d exp=%0d", got[0], exp_q[0]); end
        checks++;
        if (got[1] !== exp_q[1]) begin failures++; $display("FAIL bp_out1 got=%0d exp=%0d", got[1], exp_q[1]); end
        checks++;
        if (wr_cyc[1] - wr_cyc[0] < 37) begin
            failures++; $display("FAIL bp_single_push gap=%0d exp>=37", wr_cyc[1] - wr_cyc[0]);
        end
    endtask

    task automatic test_reset_mid_div();
        clear_logs();
        push(-1024, 512);
        wait_pop(1, 50, "rstmid");
        repeat (10) tick();
        reset = 1'b0;
        repeat (2) tick();
        m_pi = 0;
        m_pq = 0;
        reset = 1'b1;
        repeat (50) tick();
        checks++;
        if (got.size() != 0) begin failures++; $display("FAIL rstmid_stale pushes=%0d exp=0", got.size()); end
        push(1024, 0);
        wait_out(1, 100, "rstmid");
        repeat (5) tick();
        checks++;
        if (got[0] !== 1190) begin failures++; $display("FAIL rstmid_out got=%0d exp=1190", got[0]); end
        checks++;
        if (got.size() != 1) begin failures++; $display("FAIL rstmid_count pushes=%0d exp=1", got.size()); end
`ifdef DEMODULATE_PARAM_STATS_EN
        checks++;
        if (sample_count !== 32'd1) begin failures++; $display("FAIL rstmid_sample_count got=%0d exp=1", sample_count); end
`endif
    endtask

    task automatic test_stall_and_random();
        int bad = 0;
        int k = 0;
        clear_logs();
        stall_b = 1'b1;
        push(100, 200);
        for (int c = 0; c < 10; c++) begin
            tick();
            if (inA_rd_en !== 1'b0 || inB_rd_en !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL stall_rd_en cycles=%0d exp=0", bad); end
        checks++;
        if (qa.size() != 1 || qb.size() != 1) begin
            failures++; $display("FAIL stall_no_pop qa=%0d qb=%0d exp=1,1", qa.size(), qb.size());
        end
        stall_b = 1'b0;
        for (int n = 1; n < 64; n++)
            push(int'($urandom_range(4095)) - 2048, int'($urandom_range(4095)) - 2048);
        while (got.size() < 64 && k < 20000) begin
            tick();
            k++;
            stall_b  = ($urandom_range(3) == 0);
            out_full = ($urandom_range(3) == 0);
            refresh();
        end
        stall_b = 1'b0;
        out_full = 1'b0;
        refresh();
        repeat (5) tick();
        checks++;
        if (got.size() != 64) begin failures++; $display("FAIL rand_count pushes=%0d exp=64", got.size()); end
        for (int n = 0; n < 64; n++) begin
            checks++;
            if (got[n] !== exp_q[n]) begin
                failures++; $display("FAIL rand_out[%0d] got=%0d exp=%0d", n, got[n], exp_q[n]);
            end
        end
        checks++;
        if (pop_cyc.size() != 64) begin failures++; $display("FAIL rand_pops got=%0d exp=64", pop_cyc.size()); end
    endtask

    initial begin
        refresh();
        test_reset();
        test_first_sample();
        test_sequence();
        test_negative_q();
        test_backpressure();
        test_reset_mid_div();
        test_stall_and_random();
        checks++;
        if (pair_err != 0) begin failures++; $display("FAIL rd_en_pairing cycles=%0d exp=0", pair_err); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
